// File: rtl/subway_sched_pkg.sv
// Shared types and constants for the SUBWAY map scheduler.
package subway_pkg;

  // Scheduler FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StFeed,
    StWait,
    StCollect,
    StGap
  } state_e;

  // Action codes returned by the SUBWAY engine.
  localparam logic [1:0] ACT_FWD   = 2'd0;
  localparam logic [1:0] ACT_RIGHT = 2'd1;
  localparam logic [1:0] ACT_LEFT  = 2'd2;
  localparam logic [1:0] ACT_JUMP  = 2'd3;

  // Default map geometry of the engine.
  localparam int unsigned DefMapRows = 64;
  localparam int unsigned DefOutLen  = 63;

endpackage

// File: rtl/subway_sched_if.sv
// Scheduler <-> SUBWAY engine bus. master = scheduler, slave = engine.
interface subway_sched_if;
  logic       sw_in_valid;
  logic [1:0] sw_init;
  logic [1:0] sw_in0;
  logic [1:0] sw_in1;
  logic [1:0] sw_in2;
  logic [1:0] sw_in3;
  logic       sw_out_valid;
  logic [1:0] sw_out;

  modport master (
    output sw_in_valid, sw_init, sw_in0, sw_in1, sw_in2, sw_in3,
    input  sw_out_valid, sw_out
  );

  modport slave (
    input  sw_in_valid, sw_init, sw_in0, sw_in1, sw_in2, sw_in3,
    output sw_out_valid, sw_out
  );
endinterface

// File: rtl/subway_rr_arb.sv
// Combinational round-robin picker: first set req bit after last_gnt, wrapping mod NUM_REQ.
module subway_rr_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdW-1:0]     last_gnt,
  output logic               any,
  output logic [IdW-1:0]     idx
);

  // Scan candidates last_gnt+1 .. last_gnt+NUM_REQ; the modulo keeps odd sizes in range.
  always_comb begin
    int unsigned cand;
    logic [IdW-1:0] cand_id;
    any = 1'b0;
    idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand    = (32'(last_gnt) + k) % NUM_REQ;
      cand_id = IdW'(cand);
      if (!any && req[cand_id]) begin
        any = 1'b1;
        idx = cand_id;
      end
    end
  end

endmodule

// File: rtl/subway_sched.sv
// Round-robin scheduler sharing one SUBWAY engine between NUM_REQ map sources.
// Optional watchdog abort enabled by defining SUBWAY_SCHED_WDOG_EN.
module subway_sched
  import subway_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAP_ROWS = DefMapRows,
  parameter int unsigned OUT_LEN  = DefOutLen,
  parameter int unsigned WDOG_CYC = 255,
  localparam int unsigned IdW     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [2*NUM_REQ-1:0] req_init,
  input  logic [8*NUM_REQ-1:0] req_row,
  output logic [NUM_REQ-1:0]   row_pop,
  subway_sched_if.master       sw,
  output logic                 res_valid,
  output logic [1:0]           res_action,
  output logic [IdW-1:0]       res_id,
  output logic                 res_last,
  output logic                 busy,
  output logic                 wdog_err
);

  localparam int unsigned RowW = $clog2(MAP_ROWS + 1);
  localparam int unsigned CntW = $clog2(OUT_LEN + 1);

  state_e         state_q, state_d;
  logic [RowW-1:0] row_cnt_q, row_cnt_d;
  logic [CntW-1:0] res_cnt_q, res_cnt_d;
  logic [IdW-1:0]  gnt_id_q, gnt_id_d, last_gnt_q, last_gnt_d;
  logic            in_valid_q, in_valid_d;
  logic [1:0]      init_q, init_d;
  logic [7:0]      row_q, row_d;
  logic            res_valid_q, res_valid_d, res_last_q, res_last_d;
  logic [1:0]      res_action_q, res_action_d;
  logic [IdW-1:0]  res_id_q, res_id_d;
  logic            arb_any, act_last, wdog_hit;
  logic [IdW-1:0]  arb_idx;

  subway_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IdW     (IdW)
  ) u_arb (
    .req      (req),
    .last_gnt (last_gnt_q),
    .any      (arb_any),
    .idx      (arb_idx)
  );

  // The action being accepted now is the OUT_LEN-th one.
  assign act_last = (res_cnt_q == CntW'(OUT_LEN - 1));

`ifdef SUBWAY_SCHED_WDOG_EN
  logic [7:0] wdog_q, wdog_d;
  logic       wdog_err_q;

  // Count idle engine cycles while a result is owed; any out_valid restarts the count.
  always_comb begin
    wdog_d   = '0;
    wdog_hit = 1'b0;
    if ((state_q == StWait || state_q == StCollect) && !sw.sw_out_valid) begin
      wdog_d   = wdog_q + 1'b1;
      wdog_hit = (wdog_q == 8'(WDOG_CYC - 1));
    end
  end

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q     <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_q     <= wdog_d;
      wdog_err_q <= wdog_err_q | wdog_hit;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = ^WDOG_CYC;
  assign wdog_hit        = 1'b0;
  assign wdog_err        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:            if (arb_any) state_d = StFeed;
      StFeed:            if (row_cnt_q == RowW'(MAP_ROWS - 1)) state_d = StWait;
      StWait, StCollect: begin
        if (wdog_hit)             state_d = StGap;
        else if (sw.sw_out_valid) state_d = act_last ? StGap : StCollect;
      end
      StGap:             state_d = StIdle;
      default:           state_d = StIdle;
    endcase
  end

  // Output decode and next values of the registered datapath.
  always_comb begin
    row_pop      = '0;
    busy         = (state_q != StIdle);
    in_valid_d   = 1'b0;
    init_d       = '0;
    row_d        = '0;
    res_valid_d  = 1'b0;
    res_action_d = ACT_FWD;
    res_id_d     = '0;
    res_last_d   = 1'b0;
    row_cnt_d    = row_cnt_q;
    res_cnt_d    = res_cnt_q;
    gnt_id_d     = gnt_id_q;
    last_gnt_d   = last_gnt_q;
    unique case (state_q)
      StIdle: begin
        row_cnt_d = '0;
        res_cnt_d = '0;
        if (arb_any) begin
          gnt_id_d   = arb_idx;
          last_gnt_d = arb_idx;
        end
      end
      StFeed: begin
        row_pop[gnt_id_q] = 1'b1;
        in_valid_d        = 1'b1;
        row_d             = req_row[8*gnt_id_q +: 8];
        if (row_cnt_q == '0) init_d = req_init[2*gnt_id_q +: 2];
        row_cnt_d         = row_cnt_q + 1'b1;
      end
      StWait, StCollect: begin
        // Watchdog abort looks like a final forward action so consumers always see res_last.
        if (wdog_hit) begin
          res_valid_d = 1'b1;
          res_last_d  = 1'b1;
          res_id_d    = gnt_id_q;
        end else if (sw.sw_out_valid) begin
          res_valid_d  = 1'b1;
          res_action_d = sw.sw_out;
          res_id_d     = gnt_id_q;
          res_last_d   = act_last;
          res_cnt_d    = res_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; last_gnt resets to NUM_REQ-1 so requester 0 wins the first pick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt_q    <= '0;
      res_cnt_q    <= '0;
      gnt_id_q     <= '0;
      last_gnt_q   <= IdW'(NUM_REQ - 1);
      in_valid_q   <= 1'b0;
      init_q       <= '0;
      row_q        <= '0;
      res_valid_q  <= 1'b0;
      res_action_q <= '0;
      res_id_q     <= '0;
      res_last_q   <= 1'b0;
    end else begin
      row_cnt_q    <= row_cnt_d;
      res_cnt_q    <= res_cnt_d;
      gnt_id_q     <= gnt_id_d;
      last_gnt_q   <= last_gnt_d;
      in_valid_q   <= in_valid_d;
      init_q       <= init_d;
      row_q        <= row_d;
      res_valid_q  <= res_valid_d;
      res_action_q <= res_action_d;
      res_id_q     <= res_id_d;
      res_last_q   <= res_last_d;
    end
  end

  assign sw.sw_in_valid = in_valid_q;
  assign sw.sw_init     = init_q;
  assign sw.sw_in0      = row_q[1:0];
  assign sw.sw_in1      = row_q[3:2];
  assign sw.sw_in2      = row_q[5:4];
  assign sw.sw_in3      = row_q[7:6];
  assign res_valid      = res_valid_q;
  assign res_action     = res_action_q;
  assign res_id         = res_id_q;
  assign res_last       = res_last_q;

endmodule

// File: tb/tb_subway_sched.sv
// Bench for subway_sched: map sources and SUBWAY engine modelled in the bench.
module tb_subway_sched;

  localparam int NR   = 4;
  localparam int ROWS = 64;
  localparam int OUTN = 63;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req;
  logic [2*NR-1:0] req_init;
  logic [8*NR-1:0] req_row;
  logic [NR-1:0]   row_pop;
  logic            res_valid;
  logic [1:0]      res_action;
  logic [1:0]      res_id;
  logic            res_last;
  logic            busy;
  logic            wdog_err;

  subway_sched_if sw_bus ();

  subway_sched #(
    .NUM_REQ (NR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_init   (req_init),
    .req_row    (req_row),
    .row_pop    (row_pop),
    .sw         (sw_bus),
    .res_valid  (res_valid),
    .res_action (res_action),
    .res_id     (res_id),
    .res_last   (res_last),
    .busy       (busy),
    .wdog_err   (wdog_err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] rows [NR][ROWS];
  logic [1:0] init_v [NR];
  int         ptr [NR];
  int         given [NR];
  int         started [NR];
  logic       ptr_clr = 1'b0;
  int         m_pend [NR];
  int         m_last;

  // Map sources: request while a map is outstanding, present the current row.
  always_comb begin
    req      = '0;
    req_row  = '0;
    req_init = '0;
    for (int i = 0; i < NR; i++) begin
      req[i]           = (given[i] != started[i]);
      req_row[8*i +: 8] = rows[i][ptr[i]];
      req_init[2*i +: 2] = init_v[i];
    end
  end

  // Map sources advance on a pop; the first pop of a map retires its request.
  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (ptr_clr) ptr[i] <= 0;
      else if (row_pop[i]) begin
        if (ptr[i] == 0) started[i] <= started[i] + 1;
        ptr[i] <= (ptr[i] + 1) % ROWS;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first pending requester after the previous grant.
  function automatic int rr_pick(input int last);
    int best = -1;
    for (int k = 1; k <= NR; k++) begin
      if (best < 0 && m_pend[(last + k) % NR] > 0) best = (last + k) % NR;
    end
    return best;
  endfunction

  task automatic give(input int id);
    given[id]++;
    m_pend[id]++;
  endtask

  task automatic wait_grant(output int gid);
    int w = 0;
    gid = -1;
    while (row_pop == '0 && w < 8) begin
      tick;
      w++;
    end
    for (int i = 0; i < NR; i++) if (row_pop[i]) gid = i;
  endtask

  // One complete map: feed 64 rows, engine returns 63 random actions (optional gap).
  task automatic run_map(input int gap_at, input int gap_len, output int gid);
    int exp_id;
    int lat;
    logic [1:0] act;
    exp_id = rr_pick(m_last);
    wait_grant(gid);
    chk("grant", 32'(row_pop), 32'(1 << exp_id));
    m_pend[exp_id]--;
    m_last = exp_id;
    for (int j = 0; j < ROWS; j++) begin
      chk("pop", 32'(row_pop), 32'(1 << exp_id));
      tick;
      chk("in_valid", 32'(sw_bus.sw_in_valid), 1);
      chk("row", 32'({sw_bus.sw_in3, sw_bus.sw_in2, sw_bus.sw_in1, sw_bus.sw_in0}),
          32'(rows[exp_id][j]));
      chk("init", 32'(sw_bus.sw_init), (j == 0) ? 32'(init_v[exp_id]) : 0);
    end
    chk("pop_end", 32'(row_pop), 0);
    tick;
    chk("in_valid_wait", 32'(sw_bus.sw_in_valid), 0);
    chk("busy_wait", 32'(busy), 1);
    lat = $urandom_range(0, 6);
    repeat (lat) begin
      tick;
      chk("res_idle", 32'(res_valid), 0);
    end
    for (int n = 1; n <= OUTN; n++) begin
      if (n - 1 == gap_at) begin
        repeat (gap_len) begin
          sw_bus.sw_out_valid = 1'b0;
          tick;
          chk("res_gap", 32'(res_valid), 0);
        end
      end
      act = 2'($urandom);
      sw_bus.sw_out_valid = 1'b1;
      sw_bus.sw_out = act;
      tick;
      chk("res_valid", 32'(res_valid), 1);
      chk("res_action", 32'(res_action), 32'(act));
      chk("res_id", 32'(res_id), 32'(exp_id));
      chk("res_last", 32'(res_last), (n == OUTN) ? 1 : 0);
    end
    // Engine output during GAP must be ignored.
    sw_bus.sw_out_valid = 1'b1;
    sw_bus.sw_out = 2'd3;
    chk("busy_gap", 32'(busy), 1);
    chk("in_valid_gap", 32'(sw_bus.sw_in_valid), 0);
    tick;
    sw_bus.sw_out_valid = 1'b0;
    sw_bus.sw_out = 2'd0;
    chk("res_after_gap", 32'(res_valid), 0);
    chk("last_after_gap", 32'(res_last), 0);
    chk("busy_idle", 32'(busy), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pop"}, 32'(row_pop), 0);
    chk({tag, "_in_valid"}, 32'(sw_bus.sw_in_valid), 0);
    chk({tag, "_init"}, 32'(sw_bus.sw_init), 0);
    chk({tag, "_row"}, 32'({sw_bus.sw_in3, sw_bus.sw_in2, sw_bus.sw_in1, sw_bus.sw_in0}), 0);
    chk({tag, "_res_valid"}, 32'(res_valid), 0);
    chk({tag, "_res_last"}, 32'(res_last), 0);
    chk({tag, "_res_id"}, 32'(res_id), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_wdog"}, 32'(wdog_err), 0);
  endtask

  initial begin
    int gid;
    int order [5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NR; i++) begin
      for (int j = 0; j < ROWS; j++) rows[i][j] = 8'($urandom);
      init_v[i] = 2'($urandom);
      m_pend[i] = 0;
    end
    init_v[0] = 2'd2;
    sw_bus.sw_out_valid = 1'b0;
    sw_bus.sw_out = 2'd0;
    m_last = NR - 1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick;
    chk("idle_busy", 32'(busy), 0);

    // Single requester 0.
    give(0);
    run_map(-1, 0, gid);
    chk("single_id", 32'(gid), 0);

    // Fairness from a fresh reset: all four pending, requester 0 has two maps.
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    m_last = NR - 1;
    tick;
    give(0); give(0); give(1); give(2); give(3);
    for (int k = 0; k < 5; k++) begin
      run_map(-1, 0, gid);
      chk("fair_order", 32'(gid), 32'(order[k]));
    end

    // Sparse: make last_gnt = 1, then requesters 1 and 3 pending -> 3 then 1.
    give(1);
    run_map(-1, 0, gid);
    chk("sparse_pre", 32'(gid), 1);
    give(1); give(3);
    run_map(-1, 0, gid);
    chk("sparse_first", 32'(gid), 3);
    run_map(-1, 0, gid);
    chk("sparse_second", 32'(gid), 1);

    // Gapped output: 5 idle cycles after the 20th action.
    give(2);
    run_map(20, 5, gid);
    chk("gapped_id", 32'(gid), 2);

    // Reset in the middle of FEED at row 30.
    give(0);
    wait_grant(gid);
    chk("midfeed_grant", 32'(gid), 0);
    m_pend[0]--;
    repeat (30) tick;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    tick;
    ptr_clr = 1'b1;
    tick;
    ptr_clr = 1'b0;
    chk_all_zero("midreset_hold");
    rst_n = 1'b1;
    m_last = NR - 1;
    tick;
    chk("post_reset_res", 32'(res_valid), 0);
    give(0);
    run_map(-1, 0, gid);
    chk("post_reset_id", 32'(gid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
